// File: rtl/panic_perf_pkg.sv
// Shared definitions for the PANIC latency statistics block: FSM encoding,
// accumulator widths and the saturating arithmetic used by the buckets.
`ifndef PANIC_DESC_TS_SIZE
`define PANIC_DESC_TS_SIZE 48
`endif

package panic_perf_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        DUMP = 1'b1
    } state_t;

    localparam int SUM_W = 64;
    localparam int CNT_W = 32;

    function automatic logic [SUM_W-1:0] sat_add_sum(input logic [SUM_W-1:0] a,
                                                     input logic [SUM_W-1:0] b);
        logic [SUM_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SUM_W] ? '1 : s[SUM_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] a);
        return (a == '1) ? a : a + CNT_W'(1);
    endfunction

endpackage

// File: rtl/perf_laten_sched_if.sv
// Sample input, snapshot control and report stream of perf_laten_sched.
`ifndef PANIC_DESC_TS_SIZE
`define PANIC_DESC_TS_SIZE 48
`endif

interface perf_laten_sched_if
    import panic_perf_pkg::*;
#(
    parameter int CLASS_WIDTH = 5,
    parameter int LAT_WIDTH   = `PANIC_DESC_TS_SIZE
);
    logic                   s_sample_valid;
    logic [CLASS_WIDTH-1:0] s_sample_class;
    logic [LAT_WIDTH-1:0]   s_sample_latency;
    logic                   snap_req;
    logic                   snap_clear;
    logic                   snap_busy;
    logic                   m_rpt_valid;
    logic                   m_rpt_ready;
    logic [CLASS_WIDTH-1:0] m_rpt_class;
    logic [SUM_W-1:0]       m_rpt_lat_sum;
    logic [CNT_W-1:0]       m_rpt_count;
    logic                   m_rpt_last;
    logic [31:0]            drop_count;

    // slave: the statistics block itself
    modport slave (
        input  s_sample_valid, s_sample_class, s_sample_latency,
        input  snap_req, snap_clear, m_rpt_ready,
        output snap_busy, m_rpt_valid, m_rpt_class, m_rpt_lat_sum,
        output m_rpt_count, m_rpt_last, drop_count
    );

    // master: timestamp tap plus register block driving it
    modport master (
        output s_sample_valid, s_sample_class, s_sample_latency,
        output snap_req, snap_clear, m_rpt_ready,
        input  snap_busy, m_rpt_valid, m_rpt_class, m_rpt_lat_sum,
        input  m_rpt_count, m_rpt_last, drop_count
    );

endinterface

// File: rtl/perf_bucket_bank.sv
// Live and shadow latency buckets: saturating accumulate, snapshot copy and
// optional clear of the live set at the snapshot edge.
module perf_bucket_bank
    import panic_perf_pkg::*;
#(
    parameter int CLASS_NUM   = 5,
    parameter int CLASS_WIDTH = 5,
    parameter int LAT_WIDTH   = 48
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             sample_valid,
    input  logic [CLASS_WIDTH-1:0]           sample_class,
    input  logic [LAT_WIDTH-1:0]             sample_latency,
    input  logic                             snap,
    input  logic                             clear,
    output logic [CLASS_NUM-1:0][SUM_W-1:0]  live_lat,
    output logic [CLASS_NUM-1:0][CNT_W-1:0]  live_cnt,
    output logic [CLASS_NUM-1:0][SUM_W-1:0]  shadow_lat,
    output logic [CLASS_NUM-1:0][CNT_W-1:0]  shadow_cnt
);

    logic [SUM_W-1:0] lat_ext;

    assign lat_ext = SUM_W'(sample_latency);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_lat   <= '0;
            live_cnt   <= '0;
            shadow_lat <= '0;
            shadow_cnt <= '0;
        end else begin
            // shadow captures pre-edge live values, so this edge's sample is excluded
            if (snap) begin
                shadow_lat <= live_lat;
                shadow_cnt <= live_cnt;
            end
            for (int c = 0; c < CLASS_NUM; c++) begin
                if (snap && clear) begin
                    if (sample_valid && sample_class == CLASS_WIDTH'(c)) begin
                        live_lat[c] <= lat_ext;
                        live_cnt[c] <= CNT_W'(1);
                    end else begin
                        live_lat[c] <= '0;
                        live_cnt[c] <= '0;
                    end
                end else if (sample_valid && sample_class == CLASS_WIDTH'(c)) begin
                    live_lat[c] <= sat_add_sum(live_lat[c], lat_ext);
                    live_cnt[c] <= sat_inc_cnt(live_cnt[c]);
                end
            end
        end
    end

endmodule

// File: rtl/perf_laten_sched.sv
// Per-class latency statistics: bucket bank plus snapshot/readout FSM, report
// index and saturating drop counter for out-of-range classes.
`ifndef PANIC_DESC_TS_SIZE
`define PANIC_DESC_TS_SIZE 48
`endif

module perf_laten_sched
    import panic_perf_pkg::*;
#(
    parameter int CLASS_NUM   = 5,
    parameter int CLASS_WIDTH = 5,
    parameter int LAT_WIDTH   = `PANIC_DESC_TS_SIZE
) (
    input  logic               clk,
    input  logic               rst,
    perf_laten_sched_if.slave  bus
);

    logic [CLASS_NUM-1:0][SUM_W-1:0] live_lat, shadow_lat;
    logic [CLASS_NUM-1:0][CNT_W-1:0] live_cnt, shadow_cnt;

    state_t                 state_q, state_d;
    logic                   snap_take, beat_fire, advance;
    logic [CLASS_WIDTH-1:0] idx_q, idx_nxt;
    logic [SUM_W-1:0]       nxt_lat;
    logic [CNT_W-1:0]       nxt_cnt;
    logic [CLASS_WIDTH-1:0] rpt_class_q;
    logic [SUM_W-1:0]       rpt_lat_q;
    logic [CNT_W-1:0]       rpt_cnt_q;
    logic                   rpt_last_q;
    logic [31:0]            drop_q;

    perf_bucket_bank #(
        .CLASS_NUM  (CLASS_NUM),
        .CLASS_WIDTH(CLASS_WIDTH),
        .LAT_WIDTH  (LAT_WIDTH)
    ) u_bank (
        .clk           (clk),
        .rst           (rst),
        .sample_valid  (bus.s_sample_valid),
        .sample_class  (bus.s_sample_class),
        .sample_latency(bus.s_sample_latency),
        .snap          (snap_take),
        .clear         (bus.snap_clear),
        .live_lat      (live_lat),
        .live_cnt      (live_cnt),
        .shadow_lat    (shadow_lat),
        .shadow_cnt    (shadow_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.snap_req) state_d = DUMP;
            DUMP:    if (bus.m_rpt_ready && rpt_last_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        snap_take = (state_q == IDLE) && bus.snap_req;
        beat_fire = (state_q == DUMP) && bus.m_rpt_ready;
        advance   = beat_fire && !rpt_last_q;
    end

    assign idx_nxt = idx_q + CLASS_WIDTH'(1);

    always_comb begin
        nxt_lat = '0;
        nxt_cnt = '0;
        for (int c = 0; c < CLASS_NUM; c++) begin
            if (idx_nxt == CLASS_WIDTH'(c)) begin
                nxt_lat = shadow_lat[c];
                nxt_cnt = shadow_cnt[c];
            end
        end
    end

    // beat 0 comes straight from live values: the shadow is only written at this edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q       <= '0;
            rpt_class_q <= '0;
            rpt_lat_q   <= '0;
            rpt_cnt_q   <= '0;
            rpt_last_q  <= 1'b0;
        end else if (snap_take) begin
            idx_q       <= '0;
            rpt_class_q <= '0;
            rpt_lat_q   <= live_lat[0];
            rpt_cnt_q   <= live_cnt[0];
            rpt_last_q  <= (CLASS_NUM == 1);
        end else if (advance) begin
            idx_q       <= idx_nxt;
            rpt_class_q <= idx_nxt;
            rpt_lat_q   <= nxt_lat;
            rpt_cnt_q   <= nxt_cnt;
            rpt_last_q  <= (idx_nxt == CLASS_WIDTH'(CLASS_NUM - 1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= '0;
        end else if (bus.s_sample_valid && bus.s_sample_class >= CLASS_WIDTH'(CLASS_NUM)
                     && drop_q != '1) begin
            drop_q <= drop_q + 32'd1;
        end
    end

    assign bus.snap_busy     = (state_q == DUMP);
    assign bus.m_rpt_valid   = (state_q == DUMP);
    assign bus.m_rpt_class   = rpt_class_q;
    assign bus.m_rpt_lat_sum = rpt_lat_q;
    assign bus.m_rpt_count   = rpt_cnt_q;
    assign bus.m_rpt_last    = rpt_last_q;
    assign bus.drop_count    = drop_q;

endmodule

// File: tb/tb_perf_laten_sched.sv
// Directed bench for perf_laten_sched: expected beats are queued at stimulus
// time and a negedge monitor pops and compares every accepted report beat.
module tb_perf_laten_sched;
    import panic_perf_pkg::*;

    localparam int CN = 5;
    localparam int CW = 5;
    localparam int LW = 64;

    typedef struct {
        logic [CW-1:0]    cls;
        logic [SUM_W-1:0] sum;
        logic [CNT_W-1:0] cnt;
        logic             last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   beats = 0;
    beat_t exp_q[$];

    perf_laten_sched_if #(.CLASS_WIDTH(CW), .LAT_WIDTH(LW)) bus ();

    perf_laten_sched #(.CLASS_NUM(CN), .CLASS_WIDTH(CW), .LAT_WIDTH(LW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int c, input logic [63:0] s, input logic [31:0] n);
        beat_t b;
        b.cls  = CW'(c);
        b.sum  = s;
        b.cnt  = n;
        b.last = (c == CN - 1);
        exp_q.push_back(b);
    endtask

    // queue a full report: all classes zero except the listed overrides
    task automatic push_rpt(input int c0, input logic [63:0] s0, input logic [31:0] n0,
                            input int c1, input logic [63:0] s1, input logic [31:0] n1);
        for (int c = 0; c < CN; c++) begin
            if (c == c0)      push(c, s0, n0);
            else if (c == c1) push(c, s1, n1);
            else              push(c, 64'd0, 32'd0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int c, input logic [63:0] lat);
        bus.s_sample_valid   = 1'b1;
        bus.s_sample_class   = CW'(c);
        bus.s_sample_latency = lat;
        tick();
        bus.s_sample_valid   = 1'b0;
    endtask

    task automatic snap(input logic clr);
        bus.snap_req   = 1'b1;
        bus.snap_clear = clr;
        tick();
        bus.snap_req   = 1'b0;
        bus.snap_clear = 1'b0;
        chk("busy_after_snap", 64'(bus.snap_busy), 64'd1);
        chk("valid_after_snap", 64'(bus.m_rpt_valid), 64'd1);
    endtask

    task automatic wait_idle(input int max, output int cyc);
        cyc = 0;
        while (bus.snap_busy && cyc < max) begin
            tick();
            cyc++;
        end
        if (bus.snap_busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: snap_busy still 1 after %0d cycles", max);
        end
    endtask

    // monitor: stall stability plus scoreboard compare on each accepted beat
    beat_t held;
    logic  stalled = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else if (bus.m_rpt_valid) begin
            if (stalled) begin
                chk("hold_class", 64'(bus.m_rpt_class), 64'(held.cls));
                chk("hold_sum", bus.m_rpt_lat_sum, held.sum);
                chk("hold_count", 64'(bus.m_rpt_count), 64'(held.cnt));
            end
            if (!bus.m_rpt_ready) begin
                held.cls  = bus.m_rpt_class;
                held.sum  = bus.m_rpt_lat_sum;
                held.cnt  = bus.m_rpt_count;
                held.last = bus.m_rpt_last;
                stalled   = 1'b1;
            end else begin
                stalled = 1'b0;
                beats++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: class %0d with empty scoreboard", bus.m_rpt_class);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_class", 64'(bus.m_rpt_class), 64'(e.cls));
                    chk("beat_sum", bus.m_rpt_lat_sum, e.sum);
                    chk("beat_count", 64'(bus.m_rpt_count), 64'(e.cnt));
                    chk("beat_last", 64'(bus.m_rpt_last), 64'(e.last));
                end
            end
        end
    end

    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int cyc;
        int b0;
        bus.s_sample_valid   = 1'b0;
        bus.s_sample_class   = '0;
        bus.s_sample_latency = '0;
        bus.snap_req         = 1'b0;
        bus.snap_clear       = 1'b0;
        bus.m_rpt_ready      = 1'b1;
        #12;
        chk("rst_busy", 64'(bus.snap_busy), 64'd0);
        chk("rst_valid", 64'(bus.m_rpt_valid), 64'd0);
        chk("rst_sum", bus.m_rpt_lat_sum, 64'd0);
        chk("rst_count", 64'(bus.m_rpt_count), 64'd0);
        chk("rst_last", 64'(bus.m_rpt_last), 64'd0);
        chk("rst_drop", 64'(bus.drop_count), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // basic accumulate and report
        sample(2, 64'd100);
        sample(2, 64'd50);
        sample(0, 64'd7);
        push_rpt(0, 64'd7, 32'd1, 2, 64'd150, 32'd2);
        snap(1'b1);
        wait_idle(50, cyc);
        chk("basic_cycles", 64'(cyc), 64'd5);

        // clear with same-edge sample: old value reported, sample lands in new epoch
        sample(1, 64'd40);
        push_rpt(1, 64'd40, 32'd1, -1, 64'd0, 32'd0);
        bus.s_sample_valid   = 1'b1;
        bus.s_sample_class   = CW'(1);
        bus.s_sample_latency = 64'd9;
        snap(1'b1);
        bus.s_sample_valid   = 1'b0;
        wait_idle(50, cyc);
        push_rpt(1, 64'd9, 32'd1, -1, 64'd0, 32'd0);
        snap(1'b1);
        wait_idle(50, cyc);

        // backpressure with samples arriving during the dump
        sample(0, 64'd5);
        sample(4, 64'd11);
        push_rpt(0, 64'd5, 32'd1, 4, 64'd11, 32'd1);
        snap(1'b0);
        for (int k = 0; bus.snap_busy && k < 60; k++) begin
            bus.m_rpt_ready = pat[k % 4];
            if (k < 3) begin
                bus.s_sample_valid   = 1'b1;
                bus.s_sample_class   = CW'(0);
                bus.s_sample_latency = 64'd1000;
            end
            tick();
            bus.s_sample_valid = 1'b0;
        end
        bus.m_rpt_ready = 1'b1;
        wait_idle(10, cyc);
        push_rpt(0, 64'd3005, 32'd4, 4, 64'd11, 32'd1);
        snap(1'b1);
        wait_idle(50, cyc);

        // request during busy is ignored
        sample(3, 64'd77);
        push_rpt(3, 64'd77, 32'd1, -1, 64'd0, 32'd0);
        b0 = beats;
        snap(1'b1);
        bus.snap_req = 1'b1;
        tick();
        tick();
        bus.snap_req = 1'b0;
        wait_idle(50, cyc);
        tick();
        chk("busy_beats", 64'(beats - b0), 64'd5);
        chk("busy_idle", 64'(bus.snap_busy), 64'd0);

        // drops and saturation
        sample(7, 64'd123);
        chk("drop_one", 64'(bus.drop_count), 64'd1);
        sample(5, 64'd1);
        chk("drop_two", 64'(bus.drop_count), 64'd2);
        sample(3, 64'hFFFF_FFFF_FFFF_FFF6);
        sample(3, 64'd20);
        push_rpt(3, 64'hFFFF_FFFF_FFFF_FFFF, 32'd2, -1, 64'd0, 32'd0);
        snap(1'b1);
        wait_idle(50, cyc);

        // reset during a dump
        sample(2, 64'd3);
        push_rpt(-1, 64'd0, 32'd0, -1, 64'd0, 32'd0);
        snap(1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", 64'(bus.m_rpt_valid), 64'd0);
        chk("rst_mid_busy", 64'(bus.snap_busy), 64'd0);
        chk("rst_mid_beats_left", 64'(exp_q.size()), 64'd3);
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_drop", 64'(bus.drop_count), 64'd0);
        chk("post_rst_sum", bus.m_rpt_lat_sum, 64'd0);
        chk("post_rst_class", 64'(bus.m_rpt_class), 64'd0);
        push_rpt(-1, 64'd0, 32'd0, -1, 64'd0, 32'd0);
        snap(1'b0);
        wait_idle(50, cyc);
        tick();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/perf_laten_sched.md
# perf_laten_sched

Per-flow-class latency statistics controller for the PANIC receive path. Accumulates per-packet latency samples into per-class buckets (64-bit latency sum, 32-bit packet count) and sequences host readout. On a snapshot request it freezes all buckets into a shadow copy, optionally clears the live buckets, and streams one report beat per class over a valid/ready interface. Sits beside the RX timestamp tap and feeds the control-plane register block.

## Interface
Parameters:
- `CLASS_NUM`, 5: number of flow classes and buckets.
- `CLASS_WIDTH`, 5: width of the class index.
- `LAT_WIDTH`, `` `PANIC_DESC_TS_SIZE ``: width of one latency sample.

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: asynchronous, active-high reset.
- `s_sample_valid` in 1: latency sample present this cycle. No backpressure; always accepted.
- `s_sample_class` in CLASS_WIDTH: flow class of the sample.
- `s_sample_latency` in LAT_WIDTH: sample value, already computed as `timestamp - ts`.
- `snap_req` in 1: single-cycle snapshot request pulse.
- `snap_clear` in 1: qualifies `snap_req`; when 1, live buckets are cleared at the snapshot.
- `snap_busy` out 1: high while a report is being streamed.
- `m_rpt_valid` out 1: report beat valid.
- `m_rpt_ready` in 1: report consumer ready.
- `m_rpt_class` out CLASS_WIDTH: class index of the beat.
- `m_rpt_lat_sum` out 64: latency sum from the shadow copy.
- `m_rpt_count` out 32: packet count from the shadow copy.
- `m_rpt_last` out 1: set on the beat for class CLASS_NUM-1.
- `drop_count` out 32: number of samples with class ≥ CLASS_NUM. Saturating; never cleared except by reset.

## Operation
- Accumulate: on a clock edge with `s_sample_valid` and class c < CLASS_NUM:
  - `lat[c] += zero-extended latency`, saturating at 2^64-1.
  - `cnt[c] += 1`, saturating at 2^32-1.
- Out-of-range class: the sample is dropped and `drop_count` increments (saturating).
- FSM states are IDLE and DUMP.
  - IDLE → DUMP when `snap_req` is high. At the same edge, the shadow copy is loaded with the live values as they stood before that edge's sample, and the index is set to 0.
  - In DUMP, `snap_req` is ignored (no queuing).
  - DUMP → IDLE at the edge where `m_rpt_valid & m_rpt_ready & m_rpt_last`.
- Snapshot with `snap_clear=1`: the live buckets become 0, except that a same-edge valid sample of class c makes `lat[c]=latency` and `cnt[c]=1`. The sample therefore belongs to the new epoch.
- Snapshot with `snap_clear=0`: the live buckets continue accumulating normally.
- Accumulation never stalls during DUMP; the streamed data comes only from the shadow copy.
- Report beat i carries `class=i`, `lat_sum=shadow_lat[i]`, `count=shadow_cnt[i]`.
  - The index advances on `valid & ready`.
  - Outputs are held stable while `valid & !ready`.

## Timing
- Sample-to-bucket latency is 1 edge: a live bucket read the cycle after the sample includes it.
- `m_rpt_valid` and `snap_busy` rise the cycle after `snap_req` is accepted. A full report takes at least CLASS_NUM cycles.
- `m_rpt_valid` does not depend combinationally on `m_rpt_ready`. All outputs are registered.
- Reset values: `snap_busy=0`, `m_rpt_valid=0`, `m_rpt_last=0`, `m_rpt_class=0`, `m_rpt_lat_sum=0`, `m_rpt_count=0`, `drop_count=0`; all live and shadow buckets are 0; FSM is in IDLE.
- Reset asserted mid-DUMP drops `m_rpt_valid` immediately (asynchronously). No partial report resumes after reset.

## Structure
- A shared package `panic_perf_pkg` holds:
  - the FSM state encoding (IDLE=0, DUMP=1),
  - the sum width (64) and count width (32),
  - the saturating-add helper function.
- One natural sub-module, `perf_bucket_bank`: the live array, shadow array, saturating accumulate, and snapshot/clear logic. The top level keeps the FSM, the report index and the drop counter.

## Test plan
- **Basic accumulate and report:** samples (class 2, 100), (2, 50), (0, 7), then `snap_req`, with `m_rpt_ready=1` held high.
  - Expect 5 beats on consecutive cycles.
  - Class 0: sum 7, count 1. Class 2: sum 150, count 2. All other classes: 0/0.
  - `m_rpt_last` is set only on class 4.
- **Clear with same-cycle sample:** prior state class 1 = 40/1; `snap_req` + `snap_clear` in the same cycle as sample (1, 9).
  - Report shows class 1 = 40/1.
  - A second snapshot afterwards shows class 1 = 9/1.
- **Backpressure:** toggle `m_rpt_ready` 1,0,0,1,…
  - Beat data is held stable while stalled; no beat is lost or duplicated.
  - Meanwhile, samples arriving during DUMP do not alter the streamed values.
- **Request during busy:** `snap_req` asserted during DUMP is ignored. Exactly 5 beats are produced, then `snap_busy=0`.
- **Drops and saturation:**
  - Sample with class 7 → `drop_count=1`, buckets unchanged.
  - Preload class 3 sum to 2^64-10, add latency 20 → sum stays at 2^64-1.
- **Reset mid-dump:** assert `rst` after beat 2. `m_rpt_valid` falls without waiting for a clock edge; all counters and `drop_count` read 0 afterwards.
